// File: rtl/reg_wb_queue.sv
// reg_wb_queue: in-order writeback buffer in front of the register file's
// single write port. Takes ALU and load results (both in one cycle if
// needed), retires one write per cycle, and offers bypass data for pending
// writes on the two read indices.
// Optional feature macro: WB_BYPASS_EN (when undefined, bypass outputs tie to 0).
module reg_wb_queue #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [IDX_W-1:0]           alu_index,
  input  logic [DATA_W-1:0]          alu_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [IDX_W-1:0]           ld_index,
  input  logic [DATA_W-1:0]          ld_data,
  output logic                       wr_en,
  output logic [IDX_W-1:0]           wr_reg_index,
  output logic [DATA_W-1:0]          wr_reg_data,
  input  logic [IDX_W-1:0]           rd_reg_index_1,
  input  logic [IDX_W-1:0]           rd_reg_index_2,
  output logic                       byp_hit_1,
  output logic                       byp_hit_2,
  output logic [DATA_W-1:0]          byp_data_1,
  output logic [DATA_W-1:0]          byp_data_2,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0]  idx_mem_q  [DEPTH];
  logic [IDX_W-1:0]  idx_mem_d  [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_en_q, wr_en_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic [CNT_W-1:0]  free_slots;
  logic              space_ok;
  logic              take_ready;
  logic              alu_push;
  logic              ld_push;
  logic              pop;
  logic [PTR_W-1:0]  wr_slot;

  // Ready depends only on registered occupancy: two free slots lets both
  // sources be accepted in the same cycle without looking at valid.
  assign free_slots = CNT_W'(DEPTH) - count_q;
  assign space_ok   = free_slots >= CNT_W'(2);
  assign take_ready = !rst && space_ok;
  assign alu_ready  = take_ready;
  assign ld_ready   = take_ready;

  // Index 0 completes the handshake but is dropped instead of queued.
  assign alu_push = alu_valid && take_ready && (alu_index != '0);
  assign ld_push  = ld_valid  && take_ready && (ld_index  != '0);
  assign pop      = (count_q != '0);

  assign wr_en        = wr_en_q;
  assign wr_reg_index = wr_idx_q;
  assign wr_reg_data  = wr_data_q;
  assign pending      = count_q;
  assign idle         = (count_q == '0) && !wr_en_q;

  // Next-state: pop head into the output stage, then append ALU (older) and load (younger).
  always_comb begin
    idx_mem_d  = idx_mem_q;
    data_mem_d = data_mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    wr_en_d    = 1'b0;
    wr_idx_d   = wr_idx_q;
    wr_data_d  = wr_data_q;
    wr_slot    = tail_q;

    if (pop) begin
      wr_en_d   = 1'b1;
      wr_idx_d  = idx_mem_q[head_q];
      wr_data_d = data_mem_q[head_q];
      head_d    = head_q + PTR_W'(1);
    end

    if (alu_push) begin
      idx_mem_d[wr_slot]  = alu_index;
      data_mem_d[wr_slot] = alu_data;
      wr_slot             = wr_slot + PTR_W'(1);
    end

    if (ld_push) begin
      idx_mem_d[wr_slot]  = ld_index;
      data_mem_d[wr_slot] = ld_data;
      wr_slot             = wr_slot + PTR_W'(1);
    end

    tail_d  = wr_slot;
    count_d = count_q + CNT_W'(alu_push) + CNT_W'(ld_push) - CNT_W'(pop);
  end

  // Control and output-stage registers; reset discards anything pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Entry storage needs no reset: occupancy is tracked by count/head/tail.
  always_ff @(posedge clk) begin
    idx_mem_q  <= idx_mem_d;
    data_mem_q <= data_mem_d;
  end

`ifdef WB_BYPASS_EN
  logic [PTR_W-1:0] byp_slot;

  // Bypass scan: output stage first, then queue oldest to youngest so the
  // youngest matching write overrides everything older.
  always_comb begin
    byp_hit_1  = 1'b0;
    byp_hit_2  = 1'b0;
    byp_data_1 = '0;
    byp_data_2 = '0;
    byp_slot   = head_q;

    if (wr_en_q && (rd_reg_index_1 != '0) && (wr_idx_q == rd_reg_index_1)) begin
      byp_hit_1  = 1'b1;
      byp_data_1 = wr_data_q;
    end
    if (wr_en_q && (rd_reg_index_2 != '0) && (wr_idx_q == rd_reg_index_2)) begin
      byp_hit_2  = 1'b1;
      byp_data_2 = wr_data_q;
    end

    for (int i = 0; i < DEPTH; i++) begin
      byp_slot = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if ((rd_reg_index_1 != '0) && (idx_mem_q[byp_slot] == rd_reg_index_1)) begin
          byp_hit_1  = 1'b1;
          byp_data_1 = data_mem_q[byp_slot];
        end
        if ((rd_reg_index_2 != '0) && (idx_mem_q[byp_slot] == rd_reg_index_2)) begin
          byp_hit_2  = 1'b1;
          byp_data_2 = data_mem_q[byp_slot];
        end
      end
    end
  end
`else
  logic unused_rd_idx;

  assign unused_rd_idx = ^{rd_reg_index_1, rd_reg_index_2};
  assign byp_hit_1     = 1'b0;
  assign byp_hit_2     = 1'b0;
  assign byp_data_1    = '0;
  assign byp_data_2    = '0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: directed cases plus random traffic, checked every
// cycle against a queue-level model of the writeback buffer.
module tb_reg_wb_queue;
  localparam int DW    = 32;
  localparam int IW    = 5;
  localparam int DEPTH = 4;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, ld_valid;
  logic          alu_ready, ld_ready;
  logic [IW-1:0] alu_index, ld_index;
  logic [DW-1:0] alu_data, ld_data;
  logic          wr_en;
  logic [IW-1:0] wr_reg_index;
  logic [DW-1:0] wr_reg_data;
  logic [IW-1:0] rd_reg_index_1, rd_reg_index_2;
  logic          byp_hit_1, byp_hit_2;
  logic [DW-1:0] byp_data_1, byp_data_2;
  logic [2:0]    pending;
  logic          idle;

  always #5 clk = ~clk;

  reg_wb_queue #(.DATA_W(DW), .IDX_W(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_index(alu_index), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_index(ld_index), .ld_data(ld_data),
    .wr_en(wr_en), .wr_reg_index(wr_reg_index), .wr_reg_data(wr_reg_data),
    .rd_reg_index_1(rd_reg_index_1), .rd_reg_index_2(rd_reg_index_2),
    .byp_hit_1(byp_hit_1), .byp_hit_2(byp_hit_2),
    .byp_data_1(byp_data_1), .byp_data_2(byp_data_2),
    .pending(pending), .idle(idle)
  );

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } ent_t;

  // Model: pending entries in acceptance order plus the one-entry output stage.
  ent_t          mq[$];
  bit            m_out_v;
  logic [IW-1:0] m_out_idx;
  logic [DW-1:0] m_out_data;

  ent_t          wlog[$];
  logic [DW-1:0] rf [32];
  int            errors = 0;
  int            checks = 0;
  bit            chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return !rst && ((DEPTH - mq.size()) >= 2);
  endfunction

  function automatic void m_byp(input logic [IW-1:0] rd, output bit hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (!BYP || rd == '0) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].idx == rd) begin
        hit = 1'b1;
        d   = mq[i].data;
        return;
      end
    end
    if (m_out_v && m_out_idx == rd) begin
      hit = 1'b1;
      d   = m_out_data;
    end
  endfunction

  // Model update on each rising edge.
  always @(posedge clk) begin
    bit   r;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_out_v    = 1'b0;
      m_out_idx  = '0;
      m_out_data = '0;
      chk_en     = 1'b1;
    end else begin
      r = (DEPTH - mq.size()) >= 2;
      if (mq.size() != 0) begin
        e          = mq.pop_front();
        m_out_v    = 1'b1;
        m_out_idx  = e.idx;
        m_out_data = e.data;
      end else begin
        m_out_v = 1'b0;
      end
      if (alu_valid && r && alu_index != '0) mq.push_back('{idx: alu_index, data: alu_data});
      if (ld_valid && r && ld_index != '0) mq.push_back('{idx: ld_index, data: ld_data});
    end
  end

  // Compare process: every cycle, mid-period; also logs issued writes.
  always @(negedge clk) begin
    bit            h1, h2;
    logic [DW-1:0] d1, d2;
    if (chk_en) begin
      m_byp(rd_reg_index_1, h1, d1);
      m_byp(rd_reg_index_2, h2, d2);
      check("alu_ready", alu_ready, m_ready());
      check("ld_ready", ld_ready, m_ready());
      check("wr_en", wr_en, m_out_v);
      check("wr_reg_index", wr_reg_index, m_out_idx);
      check("wr_reg_data", wr_reg_data, m_out_data);
      check("pending", pending, mq.size());
      check("idle", idle, (mq.size() == 0) && !m_out_v);
      check("byp_hit_1", byp_hit_1, h1);
      check("byp_data_1", byp_data_1, d1);
      check("byp_hit_2", byp_hit_2, h2);
      check("byp_data_2", byp_data_2, d2);
      if (wr_en === 1'b1) begin
        rf[wr_reg_index] = wr_reg_data;
        wlog.push_back('{idx: wr_reg_index, data: wr_reg_data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_valid();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 20; c++) begin
      if (idle === 1'b1 && mq.size() == 0 && !m_out_v) break;
      tick();
    end
    check(name, idle, 1'b1);
  endtask

  initial begin
    int w0;
    int nxt;
    int acc_cycles;
    bit rdy;

    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst = 1'b1;
    no_valid();
    alu_index = '0; alu_data = '0; ld_index = '0; ld_data = '0;
    rd_reg_index_1 = '0; rd_reg_index_2 = '0;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_pending", pending, 0);
    check("reset_wr_en", wr_en, 0);
    check("reset_wr_idx", wr_reg_index, 0);
    tick();

    // 1: single ALU write, two edges from accept to regfile update
    alu_valid = 1'b1; alu_index = 5; alu_data = 1234;
    @(negedge clk);
    check("t1_ready", alu_ready, 1);
    tick();
    no_valid();
    @(negedge clk);
    check("t1_pend1", pending, 1);
    check("t1_wr_en_early", wr_en, 0);
    @(negedge clk);
    check("t1_wr_en", wr_en, 1);
    check("t1_idx", wr_reg_index, 5);
    check("t1_data", wr_reg_data, 1234);
    @(negedge clk);
    check("t1_wr_en_after", wr_en, 0);
    tick();
    check("t1_rf5", rf[5], 1234);

    // 2: index 0 is accepted but dropped
    alu_valid = 1'b1; alu_index = 0; alu_data = 2431;
    @(negedge clk);
    check("t2_ready", alu_ready, 1);
    tick();
    no_valid();
    repeat (3) begin
      @(negedge clk);
      check("t2_wr_en", wr_en, 0);
      check("t2_pending", pending, 0);
    end
    check("t2_rf0", rf[0], 0);
    tick();

    // 3: both sources every cycle, indices 1..8
    w0 = wlog.size();
    nxt = 1;
    acc_cycles = 0;
    for (int c = 0; c < 100 && nxt <= 8; c++) begin
      alu_valid = 1'b1; alu_index = IW'(nxt);     alu_data = DW'(nxt * 16 + 3);
      ld_valid  = 1'b1; ld_index  = IW'(nxt + 1); ld_data  = DW'((nxt + 1) * 16 + 3);
      rdy = alu_ready;
      tick();
      if (rdy) begin
        nxt += 2;
        acc_cycles++;
        if (acc_cycles == 2) begin
          check("t3_pending_full", pending, 3);
          check("t3_ready_low", alu_ready, 0);
        end
      end
    end
    no_valid();
    check("t3_all_sent", nxt, 9);
    wait_idle("t3_drain");
    check("t3_count", wlog.size() - w0, 8);
    for (int k = 0; k < 8 && w0 + k < wlog.size(); k++) begin
      check("t3_order_idx", wlog[w0 + k].idx, k + 1);
      check("t3_order_data", wlog[w0 + k].data, (k + 1) * 16 + 3);
    end

    // 4 (and 6 in the non-bypass build): same-cycle writes to r7
    w0 = wlog.size();
    rd_reg_index_1 = 7;
    alu_valid = 1'b1; alu_index = 7; alu_data = 11;
    ld_valid  = 1'b1; ld_index  = 7; ld_data  = 22;
    tick();
    no_valid();
    repeat (3) begin
      @(negedge clk);
      check("t4_byp_hit", byp_hit_1, BYP);
      check("t4_byp_data", byp_data_1, BYP ? 22 : 0);
    end
    @(negedge clk);
    check("t4_byp_hit_end", byp_hit_1, 0);
    tick();
    wait_idle("t4_drain");
    rd_reg_index_1 = 0;
    check("t4_count", wlog.size() - w0, 2);
    if (wlog.size() - w0 == 2) begin
      check("t4_first", wlog[w0].data, 11);
      check("t4_second", wlog[w0 + 1].data, 22);
    end
    check("t4_rf7", rf[7], 22);

    // 5: reset with three entries pending
    w0 = wlog.size();
    alu_valid = 1'b1; alu_index = 1; alu_data = 32'hA1;
    ld_valid  = 1'b1; ld_index  = 2; ld_data  = 32'hA2;
    tick();
    alu_index = 3; alu_data = 32'hA3;
    ld_index  = 4; ld_data  = 32'hA4;
    tick();
    no_valid();
    check("t5_pending3", pending, 3);
    rst = 1'b1;
    @(negedge clk);
    check("t5_ready_in_rst", alu_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_pending0", pending, 0);
    check("t5_wr_en0", wr_en, 0);
    check("t5_ready_back", alu_ready, 1);
    repeat (5) tick();
    check("t5_no_more_writes", wlog.size() - w0, 1);

    // Random traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      alu_valid      = 1'($urandom_range(0, 1));
      ld_valid       = 1'($urandom_range(0, 1));
      alu_index      = IW'($urandom_range(0, 7));
      ld_index       = IW'($urandom_range(0, 7));
      alu_data       = $urandom;
      ld_data        = $urandom;
      rd_reg_index_1 = IW'($urandom_range(0, 7));
      rd_reg_index_2 = IW'($urandom_range(0, 7));
      rst            = ($urandom_range(0, 39) == 0);
      tick();
    end
    rst = 1'b0;
    no_valid();
    wait_idle("rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
